// File: rtl/can_rx_crc_sequencer_if.sv
// Receive-side bit stream and result signals between the frame controller and the CRC sequencer.
interface can_rx_crc_sequencer_if;
    logic        bit_in;
    logic        bit_valid;
    logic        frame_abort;
    logic        busy;
    logic [3:0]  dlc;
    logic [14:0] calc_crc;
    logic [14:0] rx_crc;
    logic        crc_ok;
    logic        crc_err;
    logic        form_err;

    modport master (
        output bit_in, bit_valid, frame_abort,
        input  busy, dlc, calc_crc, rx_crc, crc_ok, crc_err, form_err
    );

    modport slave (
        input  bit_in, bit_valid, frame_abort,
        output busy, dlc, calc_crc, rx_crc, crc_ok, crc_err, form_err
    );
endinterface

// File: rtl/can_rx_crc_sequencer.sv
// CAN base-frame receive CRC sequencer: walks SOF..DELIM on the de-stuffed bit stream,
// runs the 15-bit CRC over SOF..DATA and reports ok / CRC error / form error.
module can_rx_crc_sequencer #(
    parameter logic [14:0] POLY      = 15'h4599,
    parameter int unsigned MAX_BYTES = 8
) (
    input logic                   clk,
    input logic                   rst,
    can_rx_crc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARB, CTRL, DATA, CRC, DELIM} state_t;

    state_t      state, state_next;
    logic [6:0]  cnt, cnt_next, data_last;
    logic        rtr;
    logic [3:0]  ctrl_sh, dlc_q, dlc_new, dlc_clamped;
    logic [6:0]  nbits;
    logic [14:0] calc_q, rx_q, crc_base, crc_next;
    logic        ok_q, err_q, ferr_q;
    logic        sof, crc_step, shift_rx, shift_ctrl, latch_rtr, latch_dlc;
    logic        ok_n, err_n, ferr_n;

    // Data length is derived from the DLC nibble as it completes, so DATA can start next edge.
    always_comb begin
        dlc_new     = {ctrl_sh[2:0], bus.bit_in};
        dlc_clamped = (dlc_new > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : dlc_new;
        nbits       = rtr ? '0 : {dlc_clamped, 3'b000};
        crc_base    = sof ? '0 : calc_q;
        crc_next    = {crc_base[13:0], 1'b0} ^ ((bus.bit_in ^ crc_base[14]) ? POLY : '0);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 7'd1;
        sof        = 1'b0;
        crc_step   = 1'b0;
        shift_rx   = 1'b0;
        shift_ctrl = 1'b0;
        latch_rtr  = 1'b0;
        latch_dlc  = 1'b0;
        ok_n       = 1'b0;
        err_n      = 1'b0;
        ferr_n     = 1'b0;
        if (bus.frame_abort) begin
            state_next = IDLE;
        end else if (bus.bit_valid) begin
            unique case (state)
                IDLE: begin
                    if (!bus.bit_in) begin
                        sof        = 1'b1;
                        crc_step   = 1'b1;
                        state_next = ARB;
                    end
                end
                ARB: begin
                    crc_step = 1'b1;
                    if (cnt == 7'd11) begin
                        latch_rtr  = 1'b1;
                        state_next = CTRL;
                    end
                end
                CTRL: begin
                    crc_step   = 1'b1;
                    shift_ctrl = 1'b1;
                    if (cnt == 7'd0 && bus.bit_in) begin
                        ferr_n     = 1'b1;
                        state_next = IDLE;
                    end else if (cnt == 7'd5) begin
                        latch_dlc  = 1'b1;
                        state_next = (nbits == '0) ? CRC : DATA;
                    end
                end
                DATA: begin
                    crc_step = 1'b1;
                    if (cnt == data_last) state_next = CRC;
                end
                CRC: begin
                    shift_rx = 1'b1;
                    if (cnt == 7'd14) state_next = DELIM;
                end
                DELIM: begin
                    err_n      = (rx_q != calc_q);
                    ferr_n     = !bus.bit_in;
                    ok_n       = (rx_q == calc_q) && bus.bit_in;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end else begin
            cnt_next = cnt;
        end
        if (state_next != state) cnt_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rtr       <= 1'b0;
            ctrl_sh   <= '0;
            dlc_q     <= '0;
            data_last <= '0;
            calc_q    <= '0;
            rx_q      <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            ok_q   <= ok_n;
            err_q  <= err_n;
            ferr_q <= ferr_n;
            if (crc_step)   calc_q  <= crc_next;
            if (sof)        rx_q    <= '0;
            if (shift_rx)   rx_q    <= {rx_q[13:0], bus.bit_in};
            if (latch_rtr)  rtr     <= bus.bit_in;
            if (shift_ctrl) ctrl_sh <= {ctrl_sh[2:0], bus.bit_in};
            if (latch_dlc) begin
                dlc_q     <= dlc_new;
                data_last <= nbits - 7'd1;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.dlc      = dlc_q;
    assign bus.calc_crc = calc_q;
    assign bus.rx_crc   = rx_q;
    assign bus.crc_ok   = ok_q;
    assign bus.crc_err  = err_q;
    assign bus.form_err = ferr_q;
endmodule
